// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle signed MUL (external multiplier) / DIV (restoring) controller for HI/LO
module mul_div_sequencer #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  localparam logic [2:0] IDLE = 3'd0, MUL_WAIT = 3'd1, DIV_RUN = 3'd2, DIV_FIX = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [4:0] cnt;
  logic [31:0] dvd, dvs, rem, diff;
  logic [32:0] cur;
  logic q_neg, r_neg, ge;
  assign cur = {rem, dvd[31]};
  assign ge = cur >= {1'b0, dvs};
  assign diff = cur[31:0] - dvs;
  assign busy = state == MUL_WAIT || state == DIV_RUN || state == DIV_FIX;
  assign done = state == DONE;
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_by_zero <= 1'b0;
          if (!op) begin
            mul_a <= a;
            mul_b <= b;
            cnt <= 5'(MUL_CYCLES - 1);
            state <= MUL_WAIT;
          end else if (b == '0) begin
            div_by_zero <= 1'b1;
            state <= DONE;
          end else begin
            dvd <= a[31] ? -a : a;
            dvs <= b[31] ? -b : b;
            rem <= '0;
            cnt <= 5'd31;
            q_neg <= a[31] ^ b[31];
            r_neg <= a[31];
            state <= DIV_RUN;
          end
        end
        MUL_WAIT: if (cnt != '0) cnt <= cnt - 5'd1;
        else begin
          {hi_out, lo_out} <= mul_z;
          state <= DONE;
        end
        DIV_RUN: begin
          // the trial difference always fits in 32 bits because rem < divisor
          rem <= ge ? diff : cur[31:0];
          dvd <= {dvd[30:0], ge};
          cnt <= cnt - 5'd1;
          state <= cnt == '0 ? DIV_FIX : DIV_RUN;
        end
        DIV_FIX: begin
          lo_out <= q_neg ? -dvd : dvd;
          hi_out <= r_neg ? -rem : rem;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: randomized self-checking bench against a plain-arithmetic reference model
module tb_mul_div_sequencer;
  localparam int MC = 2;
  logic clock = 1'b0;
  logic clear, start, op, busy, done, div_by_zero;
  logic [31:0] a, b, mul_a, mul_b, hi_out, lo_out;
  logic [63:0] mul_z;
  int errors = 0, checks = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic exp_dbz = 1'b0;
  int exp_lat, lat;
  logic stable;

  mul_div_sequencer #(.MUL_CYCLES(MC)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out));

  always #5 clock = ~clock;
  assign mul_z = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

  task automatic predict(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p = sx * sy;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dbz = 1'b0;
      exp_lat = MC + 1;
    end else if (y == '0) begin
      exp_dbz = 1'b1;
      exp_lat = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
      exp_dbz = 1'b0;
      exp_lat = 34;
    end
  endtask

  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y; stable = 1'b1;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      if (busy && !o && (mul_a !== x || mul_b !== y)) stable = 1'b0;
      @(negedge clock);
      lat++;
    end
    @(negedge clock);
  endtask

  task automatic check_result(input string name);
    checks += 4;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    if (hi_out !== exp_hi) begin errors++; $display("FAIL %s hi got=%h exp=%h", name, hi_out, exp_hi); end
    if (lo_out !== exp_lo) begin errors++; $display("FAIL %s lo got=%h exp=%h", name, lo_out, exp_lo); end
    if (div_by_zero !== exp_dbz) begin errors++; $display("FAIL %s dbz got=%b exp=%b", name, div_by_zero, exp_dbz); end
  endtask

  task automatic test_reset;
    checks += 7;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", done); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset dbz got=%b exp=0", div_by_zero); end
    if (hi_out !== '0) begin errors++; $display("FAIL reset hi got=%h exp=0", hi_out); end
    if (lo_out !== '0) begin errors++; $display("FAIL reset lo got=%h exp=0", lo_out); end
    if (mul_a !== '0) begin errors++; $display("FAIL reset mul_a got=%h exp=0", mul_a); end
    if (mul_b !== '0) begin errors++; $display("FAIL reset mul_b got=%h exp=0", mul_b); end
  endtask

  task automatic test_mul;
    predict(1'b0, 32'd7, -32'sd3);
    do_op(1'b0, 32'd7, -32'sd3);
    check_result("mul_7x-3");
    predict(1'b0, 32'h8000_0000, 32'h8000_0000);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    check_result("mul_min_sq");
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL mul_operand_hold got=%b exp=1", stable); end
  endtask

  task automatic test_div;
    predict(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, -32'sd7, 32'd2);
    check_result("div_-7/2");
    predict(1'b1, 32'd100, 32'd7);
    do_op(1'b1, 32'd100, 32'd7);
    check_result("div_100/7");
    predict(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_result("div_overflow");
  endtask

  task automatic test_div_zero;
    predict(1'b1, 32'd5, 32'd0);
    do_op(1'b1, 32'd5, 32'd0);
    check_result("div_zero");
    predict(1'b0, 32'd3, 32'd4);
    do_op(1'b0, 32'd3, 32'd4);
    check_result("dbz_cleared_by_mul");
  endtask

  task automatic test_clear_mid;
    logic seen;
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_mid busy got=%b exp=0", busy); end
    if (hi_out !== '0) begin errors++; $display("FAIL clear_mid hi got=%h exp=0", hi_out); end
    if (lo_out !== '0) begin errors++; $display("FAIL clear_mid lo got=%h exp=0", lo_out); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clear_mid done_pulse got=%b exp=0", seen); end
  endtask

  task automatic test_ignored_start;
    int c, n, dc;
    predict(1'b1, 32'd1000, 32'd3);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clock);
    start = 1'b0; c = 1; n = 0; dc = 0;
    repeat (4) begin @(negedge clock); c++; end
    start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
    @(negedge clock);
    start = 1'b0; c++;
    repeat (50) begin
      @(negedge clock);
      c++;
      if (done) begin n++; dc = c; end
    end
    checks += 4;
    if (n !== 1) begin errors++; $display("FAIL ignored_start done_count got=%0d exp=1", n); end
    if (dc !== 34) begin errors++; $display("FAIL ignored_start latency got=%0d exp=34", dc); end
    if (hi_out !== exp_hi) begin errors++; $display("FAIL ignored_start hi got=%h exp=%h", hi_out, exp_hi); end
    if (lo_out !== exp_lo) begin errors++; $display("FAIL ignored_start lo got=%h exp=%h", lo_out, exp_lo); end
  endtask

  task automatic test_random;
    logic o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 9));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: x = 32'($signed(-$urandom_range(0, 1000)));
        default: ;
      endcase
      predict(o, x, y);
      do_op(o, x, y);
      check_result(o ? "rand_div" : "rand_mul");
      if (!o) begin
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL rand_operand_hold got=%b exp=1", stable); end
      end
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    test_reset;
    clear = 1'b0;
    @(negedge clock);
    test_mul;
    test_div;
    test_div_zero;
    test_clear_mid;
    test_ignored_start;
    @(negedge clock);
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
